// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types, widths and index hash for the
// branch-predictor table update path.
package bpu_pkg;

   localparam int IDX_W = 10;
   localparam int TAG_W = 8;
   localparam int ENTRY = 1 << IDX_W;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bpu_state_e;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [TAG_W-1:0] tag;
      logic             taken;
      logic [31:0]      target;
   } bpu_upd_t;

   function automatic logic [IDX_W-1:0] bpu_idx(
      input logic [31:0] pc
   );
      return {pc[29:24] ^ pc[23:18] ^ pc[17:12] ^ pc[11:6],
              pc[5:2]};
   endfunction

   function automatic bpu_upd_t bpu_mk(
      input logic [31:0] pc,
      input logic        taken,
      input logic [31:0] target
   );
      bpu_upd_t e;
      e.idx    = bpu_idx(pc);
      e.tag    = pc[31:32-TAG_W];
      e.taken  = taken;
      e.target = target;
      return e;
   endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// bpu_upd_fifo: 2-write / 1-read synchronous FIFO of table updates.
// Writes land in order push0 then push1; occupancy is wptr - rptr.
module bpu_upd_fifo
   import bpu_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic [1:0]  push_cnt_i,
   input  bpu_upd_t    push0_i,
   input  bpu_upd_t    push1_i,
   input  logic        pop_i,
   output bpu_upd_t    head_o,
   output logic [AW:0] occ_o
);

   bpu_upd_t    mem_q [DEPTH];
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic [AW-1:0] wa0, wa1;

   assign wa0 = wptr_q[AW-1:0];
   assign wa1 = wa0 + 1'b1;

   always_ff @(posedge clk_i) begin
      if (push_cnt_i != 2'd0) mem_q[wa0] <= push0_i;
      if (push_cnt_i == 2'd2) mem_q[wa1] <= push1_i;
   end

   always_comb begin
      wptr_d = wptr_q + {{(AW-1){1'b0}}, push_cnt_i};
      rptr_d = rptr_q + {{AW{1'b0}}, pop_i};
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   assign occ_o  = wptr_q - rptr_q;
   assign head_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/bpu_upd_sched.sv
// bpu_upd_sched: buffers EX branch resolutions and drains them to the
// BHT/BTB write port; sequences the invalidate sweep. Option: BPU_UPD_BYPASS_EN.
module bpu_upd_sched #(
   parameter int DEPTH = 8,
   parameter int IDX_W = 10,
   parameter int TAG_W = 8
) (
   input  logic             cpu_clk,
   input  logic             cpu_rstn,
   input  logic             clr_req,
   input  logic             ex_valid1,
   input  logic             ex_is_bj_1,
   input  logic [31:0]      ex_pc_1,
   input  logic             real_taken1,
   input  logic [31:0]      real_addr1,
   input  logic             ex_valid2,
   input  logic             ex_is_bj_2,
   input  logic [31:0]      ex_pc_2,
   input  logic             real_taken2,
   input  logic [31:0]      real_addr2,
   output logic             upd_ready,
   output logic             tbl_valid,
   input  logic             tbl_ready,
   output logic             tbl_clr,
   output logic [IDX_W-1:0] tbl_idx,
   output logic [TAG_W-1:0] tbl_tag,
   output logic             tbl_taken,
   output logic [31:0]      tbl_target,
   output logic             init_busy,
   output logic [15:0]      drop_cnt
);

   import bpu_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] TWO_C = (AW+1)'(2);
   localparam logic [IDX_W-1:0] SWEEP_MAX = '1;
   localparam int PT = bpu_pkg::TAG_W;

   bpu_state_e       state_q, state_d;
   logic [IDX_W-1:0] sweep_q, sweep_d;
   logic             vld_q, vld_d;
   logic             clr_q, clr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             tkn_q, tkn_d;
   logic [31:0]      tgt_q, tgt_d;
   logic             rdy_q, rdy_d;
   logic [15:0]      drop_q, drop_d;
   logic [16:0]      drop_sum;

   bpu_upd_t    e1, e2, s0, s1, f0, f1, head;
   logic        elig1, elig2, run, fits, accept, drop;
   logic        byp, byp_fire, load_en, direct, pop, f_empty;
   logic [1:0]  n_elig, s_cnt, f_cnt;
   logic [AW:0] occ, occ_nxt, free;

   assign e1 = bpu_mk(ex_pc_1, real_taken1, real_addr1);
   assign e2 = bpu_mk(ex_pc_2, real_taken2, real_addr2);

   // A taken slot 1 redirects fetch, so slot 2 is wrong-path.
   assign elig1  = ex_valid1 & ex_is_bj_1;
   assign elig2  = ex_valid2 & ex_is_bj_2 & ~(elig1 & real_taken1);
   assign n_elig = {1'b0, elig1} + {1'b0, elig2};

   assign run     = (state_q == ST_RUN);
   assign f_empty = (occ == '0);
   assign free    = DEPTH_C - occ;
   assign fits    = free >= {{(AW-1){1'b0}}, n_elig};
   assign accept  = run & ~clr_req & fits & (n_elig != 2'd0);
   assign drop    = run & ~clr_req & ~fits;
   assign load_en = run & (~vld_q | tbl_ready);

`ifdef BPU_UPD_BYPASS_EN
   assign byp = run & f_empty & ~vld_q & elig1 & ~clr_req;
`else
   assign byp = 1'b0;
`endif
   assign byp_fire = byp & tbl_ready;

   // Accepted entries in program order, minus any bypassed slot 1.
   always_comb begin
      s0    = byp_fire ? e2 : (elig1 ? e1 : e2);
      s1    = e2;
      s_cnt = 2'd0;
      if (accept) s_cnt = byp_fire ? n_elig - 2'd1 : n_elig;
   end

   // An idle output stage takes the first entry straight away.
   assign direct = load_en & f_empty & (s_cnt != 2'd0);
   assign f_cnt  = direct ? s_cnt - 2'd1 : s_cnt;
   assign f0     = direct ? s1 : s0;
   assign f1     = s1;

   bpu_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i      (cpu_clk),
      .rst_ni     (cpu_rstn),
      .flush_i    (clr_req),
      .push_cnt_i (f_cnt),
      .push0_i    (f0),
      .push1_i    (f1),
      .pop_i      (pop),
      .head_o     (head),
      .occ_o      (occ)
   );

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      vld_d   = vld_q;
      clr_d   = clr_q;
      idx_d   = idx_q;
      tag_d   = tag_q;
      tkn_d   = tkn_q;
      tgt_d   = tgt_q;
      pop     = 1'b0;
      if (clr_req) begin
         state_d = ST_INIT;
         sweep_d = '0;
         vld_d   = 1'b1;
         clr_d   = 1'b1;
         idx_d   = '0;
         tag_d   = '0;
         tkn_d   = 1'b0;
         tgt_d   = '0;
      end else if (state_q == ST_INIT) begin
         vld_d = 1'b1;
         clr_d = 1'b1;
         idx_d = sweep_q;
         if (vld_q && tbl_ready) begin
            if (sweep_q == SWEEP_MAX) begin
               state_d = ST_RUN;
               sweep_d = '0;
               vld_d   = 1'b0;
               clr_d   = 1'b0;
            end else begin
               sweep_d = sweep_q + 1'b1;
               idx_d   = sweep_q + 1'b1;
            end
         end
      end else if (load_en) begin
         clr_d = 1'b0;
         if (direct) begin
            vld_d = 1'b1;
            idx_d = s0.idx[IDX_W-1:0];
            tag_d = s0.tag[PT-1 -: TAG_W];
            tkn_d = s0.taken;
            tgt_d = s0.target;
         end else if (!f_empty) begin
            vld_d = 1'b1;
            idx_d = head.idx[IDX_W-1:0];
            tag_d = head.tag[PT-1 -: TAG_W];
            tkn_d = head.taken;
            tgt_d = head.target;
            pop   = 1'b1;
         end else begin
            vld_d = 1'b0;
         end
      end
   end

   always_comb begin
      occ_nxt  = occ + {{(AW-1){1'b0}}, f_cnt} - {{AW{1'b0}}, pop};
      if (clr_req) occ_nxt = '0;
      rdy_d    = ((DEPTH_C - occ_nxt) >= TWO_C) & (state_d == ST_RUN);
      drop_sum = {1'b0, drop_q} + {15'd0, n_elig};
      drop_d   = drop_q;
      if (drop) drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state_q <= ST_INIT;
         sweep_q <= '0;
         vld_q   <= 1'b0;
         clr_q   <= 1'b0;
         idx_q   <= '0;
         tag_q   <= '0;
         tkn_q   <= 1'b0;
         tgt_q   <= '0;
         rdy_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         vld_q   <= vld_d;
         clr_q   <= clr_d;
         idx_q   <= idx_d;
         tag_q   <= tag_d;
         tkn_q   <= tkn_d;
         tgt_q   <= tgt_d;
         rdy_q   <= rdy_d;
         drop_q  <= drop_d;
      end
   end

   assign tbl_valid  = vld_q | byp;
   assign tbl_clr    = clr_q;
   assign tbl_idx    = byp ? e1.idx[IDX_W-1:0] : idx_q;
   assign tbl_tag    = byp ? e1.tag[PT-1 -: TAG_W] : tag_q;
   assign tbl_taken  = byp ? e1.taken : tkn_q;
   assign tbl_target = byp ? e1.target : tgt_q;
   assign upd_ready  = rdy_q;
   assign init_busy  = (state_q == ST_INIT);
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_bpu_upd_sched.sv
// tb_bpu_upd_sched: directed vector table plus hand sequences for
// sweep, backpressure/drop, clear and latency of bpu_upd_sched.
module tb_bpu_upd_sched;

`ifdef BPU_UPD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        cpu_clk = 1'b0;
   logic        cpu_rstn, clr_req;
   logic        ex_valid1, ex_is_bj_1, real_taken1;
   logic        ex_valid2, ex_is_bj_2, real_taken2;
   logic [31:0] ex_pc_1, real_addr1, ex_pc_2, real_addr2;
   logic        upd_ready, tbl_valid, tbl_ready, tbl_clr;
   logic [3:0]  tbl_idx;
   logic [7:0]  tbl_tag;
   logic        tbl_taken, init_busy;
   logic [31:0] tbl_target;
   logic [15:0] drop_cnt;

   typedef struct packed {
      logic [3:0]  idx;
      logic [7:0]  tag;
      logic        tk;
      logic [31:0] tgt;
   } wr_t;

   typedef struct {
      logic v1, b1, t1;
      logic [31:0] pc1, a1;
      logic v2, b2, t2;
      logic [31:0] pc2, a2;
      int  nw;
      wr_t w0, w1;
   } vec_t;

   wr_t        wq[$];
   logic [3:0] cq[$];
   int         n_pass = 0;
   int         n_tot  = 0;

   bpu_upd_sched #(.DEPTH(8), .IDX_W(4), .TAG_W(8)) dut (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .clr_req(clr_req),
      .ex_valid1(ex_valid1), .ex_is_bj_1(ex_is_bj_1), .ex_pc_1(ex_pc_1),
      .real_taken1(real_taken1), .real_addr1(real_addr1),
      .ex_valid2(ex_valid2), .ex_is_bj_2(ex_is_bj_2), .ex_pc_2(ex_pc_2),
      .real_taken2(real_taken2), .real_addr2(real_addr2),
      .upd_ready(upd_ready), .tbl_valid(tbl_valid), .tbl_ready(tbl_ready),
      .tbl_clr(tbl_clr), .tbl_idx(tbl_idx), .tbl_tag(tbl_tag),
      .tbl_taken(tbl_taken), .tbl_target(tbl_target),
      .init_busy(init_busy), .drop_cnt(drop_cnt)
   );

   always #5 cpu_clk = ~cpu_clk;

   always @(negedge cpu_clk) begin
      if (cpu_rstn && tbl_valid && tbl_ready) begin
         if (tbl_clr) cq.push_back(tbl_idx);
         else wq.push_back({tbl_idx, tbl_tag, tbl_taken, tbl_target});
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic drive(input logic v1, b1, t1, input logic [31:0] p1, a1,
                        input logic v2, b2, t2, input logic [31:0] p2, a2);
      ex_valid1 = v1; ex_is_bj_1 = b1; real_taken1 = t1;
      ex_pc_1 = p1; real_addr1 = a1;
      ex_valid2 = v2; ex_is_bj_2 = b2; real_taken2 = t2;
      ex_pc_2 = p2; real_addr2 = a2;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push_pair(input int j, input logic [31:0] base);
      drive(1, 1, 0, 32'h1c000000 + 4 * j, base + j,
            1, 1, 0, 32'h1c000004 + 4 * j, base + j + 1);
   endtask

   task automatic wait_run();
      for (int i = 0; i < 200; i++) begin
         if (!init_busy) break;
         cyc();
      end
   endtask

   vec_t        vt[6];
   logic [15:0] drop0;
   logic        ur[4];
   int          bad;

   initial begin
      vt[0] = '{1, 1, 0, 32'h1c000010, 32'h1c000014,
                1, 1, 1, 32'h1c000014, 32'h1c000100, 2,
                {4'h4, 8'h1c, 1'b0, 32'h1c000014},
                {4'h5, 8'h1c, 1'b1, 32'h1c000100}};
      vt[1] = '{1, 1, 1, 32'h1c000020, 32'h1c000200,
                1, 1, 1, 32'h1c000024, 32'h1c000300, 1,
                {4'h8, 8'h1c, 1'b1, 32'h1c000200}, 45'd0};
      vt[2] = '{1, 0, 1, 32'h1c000040, 32'h1c000444,
                1, 1, 1, 32'h8000003c, 32'h80000000, 1,
                {4'hf, 8'h80, 1'b1, 32'h80000000}, 45'd0};
      vt[3] = '{1, 0, 0, 32'h1c000044, 32'h1c000048,
                0, 1, 1, 32'h1c000048, 32'h1c000800, 0, 45'd0, 45'd0};
      vt[4] = '{0, 1, 1, 32'h1c000050, 32'h1c000900,
                1, 1, 0, 32'h40000008, 32'h4000000c, 1,
                {4'h2, 8'h40, 1'b0, 32'h4000000c}, 45'd0};
      vt[5] = '{1, 1, 0, 32'hfffffffc, 32'h00000000,
                1, 1, 1, 32'h00000000, 32'h12345678, 2,
                {4'hf, 8'hff, 1'b0, 32'h00000000},
                {4'h0, 8'h00, 1'b1, 32'h12345678}};

      cpu_rstn = 0; clr_req = 0; tbl_ready = 1; idle();
      #2;
      chk("rst_tbl_valid", tbl_valid, 0);
      chk("rst_tbl_clr", tbl_clr, 0);
      chk("rst_tbl_idx", tbl_idx, 0);
      chk("rst_tbl_target", tbl_target, 0);
      chk("rst_upd_ready", upd_ready, 0);
      chk("rst_init_busy", init_busy, 1);
      chk("rst_drop_cnt", drop_cnt, 0);
      cyc(); cyc();
      cpu_rstn = 1;

      wait_run();
      chk("sweep_done", init_busy, 0);
      chk("sweep_count", cq.size(), 16);
      bad = 0;
      for (int i = 0; i < cq.size(); i++) if (cq[i] != 4'(i)) bad++;
      chk("sweep_order", bad, 0);
      chk("sweep_upd_ready", upd_ready, 1);
      chk("sweep_no_data", wq.size(), 0);

      for (int v = 0; v < 6; v++) begin
         wq.delete();
         drop0 = drop_cnt;
         drive(vt[v].v1, vt[v].b1, vt[v].t1, vt[v].pc1, vt[v].a1,
               vt[v].v2, vt[v].b2, vt[v].t2, vt[v].pc2, vt[v].a2);
         cyc();
         idle();
         for (int k = 0; k < 4; k++) cyc();
         chk($sformatf("v%0d_count", v), wq.size(), vt[v].nw);
         if (vt[v].nw > 0 && wq.size() > 0)
            chk($sformatf("v%0d_w0", v), wq[0], vt[v].w0);
         if (vt[v].nw > 1 && wq.size() > 1)
            chk($sformatf("v%0d_w1", v), wq[1], vt[v].w1);
         chk($sformatf("v%0d_drop", v), drop_cnt, drop0);
      end

      wq.delete();
      drop0 = drop_cnt;
      tbl_ready = 0;
      for (int k = 0; k < 4; k++) begin
         push_pair(2 * k, 32'h1000);
         cyc();
         ur[k] = upd_ready;
         if (k == 0) begin
            chk("bp_first_idx", tbl_idx, 4'h0);
            chk("bp_first_tgt", tbl_target, 32'h1000);
         end
      end
      chk("bp_ready_occ3", ur[1], 1);
      chk("bp_ready_occ5", ur[2], 1);
      chk("bp_ready_occ7", ur[3], 0);
      push_pair(8, 32'h1000);
      cyc();
      idle();
      chk("bp_drop2", drop_cnt, drop0 + 16'd2);
      chk("bp_hold_valid", tbl_valid, 1);
      chk("bp_hold_idx", tbl_idx, 4'h0);
      chk("bp_hold_tgt", tbl_target, 32'h1000);
      chk("bp_hold_taken", tbl_taken, 0);
      tbl_ready = 1;
      for (int k = 0; k < 12; k++) cyc();
      chk("bp_drain_count", wq.size(), 8);
      for (int k = 0; k < 8; k++)
         if (k < wq.size())
            chk($sformatf("bp_drain%0d", k), wq[k],
                {4'(k), 8'h1c, 1'b0, 32'h1000 + k});
      chk("bp_ready_back", upd_ready, 1);

      wq.delete();
      drop0 = drop_cnt;
      tbl_ready = 0;
      for (int k = 0; k < 3; k++) begin
         push_pair(2 * k, 32'h2000);
         cyc();
      end
      idle();
      tbl_ready = 1;
      cyc();
      chk("clr_pre_write", wq.size(), 1);
      tbl_ready = 0;
      clr_req = 1;
      push_pair(0, 32'h3000);
      cyc();
      clr_req = 0;
      idle();
      chk("clr_tbl_clr", tbl_clr, 1);
      chk("clr_tbl_valid", tbl_valid, 1);
      chk("clr_tbl_idx", tbl_idx, 0);
      chk("clr_init_busy", init_busy, 1);
      chk("clr_upd_ready", upd_ready, 0);
      chk("clr_no_drop", drop_cnt, drop0);
      wq.delete();
      cq.delete();
      tbl_ready = 1;
      push_pair(4, 32'h4000);
      cyc();
      idle();
      wait_run();
      chk("clr_sweep_done", init_busy, 0);
      chk("clr_sweep_count", cq.size(), 16);
      bad = 0;
      for (int i = 0; i < cq.size(); i++) if (cq[i] != 4'(i)) bad++;
      chk("clr_sweep_order", bad, 0);
      chk("clr_queue_gone", wq.size(), 0);
      chk("init_discard_drop", drop_cnt, drop0);
      chk("clr_upd_ready_back", upd_ready, 1);

      cyc();
      wq.delete();
      drive(1, 1, 1, 32'h1c000030, 32'h1c000400, 0, 0, 0, 0, 0);
      #1;
      chk("lat_same_cycle", tbl_valid, BYP);
      if (BYP) chk("lat_byp_idx", tbl_idx, 4'hc);
      cyc();
      idle();
      chk("lat_next_cycle", tbl_valid, !BYP);
      if (!BYP) chk("lat_reg_idx", tbl_idx, 4'hc);
      cyc(); cyc();
      chk("lat_one_write", wq.size(), 1);
      if (wq.size() > 0)
         chk("lat_write", wq[0], {4'hc, 8'h1c, 1'b1, 32'h1c000400});

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
